fmc_i2c_poller: RTL and testbench

Periodic I2C status poller that sits directly upstream of the single-byte I2C read engine on the FMC I2C path. It walks a list of up to `NUM_DEV` device addresses and presents each one to the read engine with a start pulse. For each read it either captures the returned byte into a per-device status register or records a NACK or timeout. On a timeout it resets the read engine so a stuck bus cannot hang polling.

---
 rtl/fmc_i2c_poller.sv | 152 +++++++++++++++
 tb/tb_fmc_i2c_poller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fmc_i2c_poller.sv
// rtl/fmc_i2c_poller.sv - periodic I2C status poller driving a single-byte read engine
module fmc_i2c_poller #(
  parameter int NUM_DEV     = 2,
  parameter int POLL_PERIOD = 125000,
  parameter int TIMEOUT     = 2500000
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 enable,
  input  logic [8*NUM_DEV-1:0] dev_adr_list,
  output logic [7:0]           i2c_dev_adr,
  output logic                 i2c_start_read,
  output logic                 i2c_rst,
  input  logic                 i2c_byte_rdy,
  input  logic [7:0]           i2c_rd_dat,
  input  logic                 i2c_error,
  output logic [8*NUM_DEV-1:0] status_dat,
  output logic [NUM_DEV-1:0]   status_valid,
  output logic                 status_change,
  output logic [2:0]           change_idx,
  output logic [NUM_DEV-1:0]   dev_err,
  output logic [15:0]          err_cnt
);

  localparam int PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] P_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    I_LAST = 3'(NUM_DEV - 1);

  typedef enum logic [2:0] {HOLDOFF, START, BUSY, CAPTURE, RECOVER} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    rcnt;
  logic [2:0]    idx;
  logic          nack;

  logic [7:0] cur_adr;
  logic [7:0] cur_dat;
  logic       cur_valid;
  logic [2:0] idx_next;

  always_comb begin
    cur_adr   = '0;
    cur_dat   = '0;
    cur_valid = 1'b0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (idx == 3'(k)) begin
        cur_adr   = dev_adr_list[8*k +: 8];
        cur_dat   = status_dat[8*k +: 8];
        cur_valid = status_valid[k];
      end
    end
    idx_next = (idx == I_LAST) ? 3'd0 : idx + 3'd1;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state          <= HOLDOFF;
      pcnt           <= P_LAST;
      tcnt           <= '0;
      rcnt           <= '0;
      idx            <= '0;
      nack           <= 1'b0;
      i2c_dev_adr    <= '0;
      i2c_start_read <= 1'b0;
      i2c_rst        <= 1'b0;
      status_dat     <= '0;
      status_valid   <= '0;
      status_change  <= 1'b0;
      change_idx     <= '0;
      dev_err        <= '0;
      err_cnt        <= '0;
    end else begin
      i2c_start_read <= 1'b0;
      status_change  <= 1'b0;
      case (state)
        HOLDOFF: begin
          if (!enable) begin
            pcnt <= P_LAST;
          end else if (pcnt == '0) begin
            state          <= START;
            i2c_start_read <= 1'b1;
            i2c_dev_adr    <= cur_adr;
            tcnt           <= '0;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        START: begin
          tcnt  <= tcnt + 1'b1;
          state <= BUSY;
        end
        BUSY: begin
          if (i2c_error) nack <= 1'b1;
          // Results are committed on the byte_rdy edge so they are visible in the CAPTURE cycle.
          if (i2c_byte_rdy) begin
            state <= CAPTURE;
            if (nack || i2c_error) begin
              for (int k = 0; k < NUM_DEV; k++)
                if (idx == 3'(k)) dev_err[k] <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else begin
              for (int k = 0; k < NUM_DEV; k++) begin
                if (idx == 3'(k)) begin
                  status_dat[8*k +: 8] <= i2c_rd_dat;
                  status_valid[k]      <= 1'b1;
                  dev_err[k]           <= 1'b0;
                end
              end
              if (cur_valid && (cur_dat != i2c_rd_dat)) begin
                status_change <= 1'b1;
                change_idx    <= idx;
              end
            end
          end else if (tcnt == T_LAST) begin
            state <= RECOVER;
            rcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CAPTURE: begin
          nack  <= 1'b0;
          idx   <= idx_next;
          pcnt  <= P_LAST;
          state <= HOLDOFF;
        end
        RECOVER: begin
          // First RECOVER cycle arms i2c_rst; it then stays high for four cycles.
          if (rcnt == 3'd4) begin
            i2c_rst <= 1'b0;
            for (int k = 0; k < NUM_DEV; k++)
              if (idx == 3'(k)) dev_err[k] <= 1'b1;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            nack  <= 1'b0;
            idx   <= idx_next;
            pcnt  <= P_LAST;
            state <= HOLDOFF;
          end else begin
            i2c_rst <= 1'b1;
            rcnt    <= rcnt + 3'd1;
          end
        end
        default: state <= HOLDOFF;
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_i2c_poller.sv
// tb/tb_fmc_i2c_poller.sv - directed self-checking bench for fmc_i2c_poller
module tb_fmc_i2c_poller;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] dev_adr_list = {8'h91, 8'hA1};
  logic [7:0]  i2c_dev_adr;
  logic        i2c_start_read;
  logic        i2c_rst;
  logic        i2c_byte_rdy = 1'b0;
  logic [7:0]  i2c_rd_dat = 8'h00;
  logic        i2c_error = 1'b0;
  logic [15:0] status_dat;
  logic [1:0]  status_valid;
  logic        status_change;
  logic [2:0]  change_idx;
  logic [1:0]  dev_err;
  logic [15:0] err_cnt;

  int checks = 0;
  int failures = 0;

  fmc_i2c_poller #(.NUM_DEV(2), .POLL_PERIOD(8), .TIMEOUT(16)) dut (
    .clk(clk), .nReset(nReset), .enable(enable), .dev_adr_list(dev_adr_list),
    .i2c_dev_adr(i2c_dev_adr), .i2c_start_read(i2c_start_read), .i2c_rst(i2c_rst),
    .i2c_byte_rdy(i2c_byte_rdy), .i2c_rd_dat(i2c_rd_dat), .i2c_error(i2c_error),
    .status_dat(status_dat), .status_valid(status_valid), .status_change(status_change),
    .change_idx(change_idx), .dev_err(dev_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (i2c_start_read !== 1'b1 && n < 200);
  endtask

  // Called in the START cycle; returns in the cycle after byte_rdy.
  task automatic reply(input logic [7:0] d, input logic err);
    step();
    step();
    step();
    if (err) begin
      i2c_error = 1'b1;
      step();
      i2c_error = 1'b0;
    end
    i2c_rd_dat   = d;
    i2c_byte_rdy = 1'b1;
    step();
    i2c_byte_rdy = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    step();
    step();
    chk("rst_adr", i2c_dev_adr, 8'h00);
    chk("rst_start", i2c_start_read, 1'b0);
    chk("rst_i2c_rst", i2c_rst, 1'b0);
    chk("rst_dat", status_dat, 16'h0000);
    chk("rst_valid", status_valid, 2'b00);
    chk("rst_change", status_change, 1'b0);
    chk("rst_change_idx", change_idx, 3'd0);
    chk("rst_dev_err", dev_err, 2'b00);
    chk("rst_err_cnt", err_cnt, 16'h0000);

    @(posedge clk);
    #1 nReset = 1'b1;
    wait_start(n);
    chk("first_start_lat", n, 8);
    chk("first_adr", i2c_dev_adr, 8'hA1);
    reply(8'h3C, 1'b0);
    chk("p1_dat", status_dat, 16'h003C);
    chk("p1_valid", status_valid, 2'b01);
    chk("p1_change", status_change, 1'b0);

    wait_start(n);
    chk("start_spacing", n, 9);
    chk("p2_adr", i2c_dev_adr, 8'h91);
    reply(8'h5A, 1'b0);
    chk("p2_dat", status_dat, 16'h5A3C);
    chk("p2_valid", status_valid, 2'b11);
    chk("p2_change", status_change, 1'b0);

    wait_start(n);
    chk("p3_adr", i2c_dev_adr, 8'hA1);
    reply(8'h3D, 1'b0);
    chk("chg_pulse", status_change, 1'b1);
    chk("chg_idx", change_idx, 3'd0);
    chk("chg_dat", status_dat[7:0], 8'h3D);
    step();
    chk("chg_single", status_change, 1'b0);

    wait_start(n);
    chk("nack_adr", i2c_dev_adr, 8'h91);
    reply(8'hFF, 1'b1);
    chk("nack_dev_err", dev_err, 2'b10);
    chk("nack_err_cnt", err_cnt, 16'd1);
    chk("nack_dat", status_dat[15:8], 8'h5A);
    chk("nack_change", status_change, 1'b0);

    wait_start(n);
    reply(8'h3D, 1'b0);
    chk("same_change", status_change, 1'b0);
    chk("same_dev_err", dev_err, 2'b10);

    wait_start(n);
    chk("clr_adr", i2c_dev_adr, 8'h91);
    reply(8'h11, 1'b0);
    chk("clr_dev_err", dev_err, 2'b00);
    chk("clr_dat", status_dat, 16'h113D);
    chk("clr_change", status_change, 1'b1);
    chk("clr_change_idx", change_idx, 3'd1);

    wait_start(n);
    chk("to_adr", i2c_dev_adr, 8'hA1);
    n = 0;
    do begin
      step();
      n++;
    end while (i2c_rst !== 1'b1 && n < 100);
    chk("to_rst_lat", n, 17);
    w = 0;
    while (i2c_rst === 1'b1 && w < 20) begin
      w++;
      step();
    end
    chk("to_rst_width", w, 4);
    chk("to_dev_err", dev_err, 2'b01);
    chk("to_err_cnt", err_cnt, 16'd2);

    i2c_error = 1'b1;
    step();
    i2c_error    = 1'b0;
    i2c_rd_dat   = 8'h77;
    i2c_byte_rdy = 1'b1;
    step();
    i2c_byte_rdy = 1'b0;
    step();
    chk("idle_rdy_dat", status_dat, 16'h113D);
    chk("idle_rdy_err_cnt", err_cnt, 16'd2);

    wait_start(n);
    chk("after_to_adr", i2c_dev_adr, 8'h91);
    enable = 1'b0;
    reply(8'h22, 1'b0);
    chk("en_drop_dat", status_dat, 16'h223D);
    chk("en_drop_change", status_change, 1'b1);
    chk("en_drop_dev_err", dev_err, 2'b01);
    w = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i2c_start_read === 1'b1) w++;
    end
    chk("en_drop_no_start", w, 0);
    enable = 1'b1;
    wait_start(n);
    chk("en_rise_lat", n, 8);
    chk("en_rise_adr", i2c_dev_adr, 8'hA1);
    reply(8'h3D, 1'b0);
    chk("en_rise_dev_err", dev_err, 2'b00);

    wait_start(n);
    chk("mid_adr", i2c_dev_adr, 8'h91);
    step();
    step();
    nReset = 1'b0;
    #1;
    chk("mid_rst_adr", i2c_dev_adr, 8'h00);
    chk("mid_rst_dat", status_dat, 16'h0000);
    chk("mid_rst_valid", status_valid, 2'b00);
    chk("mid_rst_err_cnt", err_cnt, 16'h0000);
    chk("mid_rst_dev_err", dev_err, 2'b00);
    step();
    @(posedge clk);
    #1 nReset = 1'b1;
    wait_start(n);
    chk("post_rst_lat", n, 8);
    chk("post_rst_adr", i2c_dev_adr, 8'hA1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
